// File: rtl/icape2_multiboot_seq.sv
// rtl/icape2_multiboot_seq.sv - ICAPE2 IPROG warm-boot sequencer with qualified boot request
module icape2_multiboot_seq #(
    parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
    parameter int          ARM_CYCLES    = 16,
    parameter bit          BITSWAP       = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boot,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_i,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [15:0] ARM_LAST = 16'(ARM_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] arm_cnt, arm_cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic        csib_nxt, rdwrb_nxt, busy_nxt, done_nxt;
    logic [31:0] data_nxt;

    function automatic logic [31:0] iprog_word(input logic [2:0] sel);
        case (sel)
            3'd0:    iprog_word = 32'hFFFF_FFFF;
            3'd1:    iprog_word = 32'hAA99_5566;
            3'd2:    iprog_word = 32'h2000_0000;
            3'd3:    iprog_word = 32'h3002_0001;
            3'd4:    iprog_word = START_ADDRESS;
            3'd5:    iprog_word = 32'h3000_8001;
            3'd6:    iprog_word = 32'h0000_000F;
            default: iprog_word = 32'h2000_0000;
        endcase
    endfunction

    // ICAPE2 expects each byte bit-reversed relative to the bitstream word order
    function automatic logic [31:0] byte_swap_bits(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b + i] = w[8*b + 7 - i];
            end
        end
        return r;
    endfunction

    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        idx_nxt     = idx;
        case (state)
            S_IDLE: begin
                if (!boot) begin
                    arm_cnt_nxt = 16'd0;
                end else if (arm_cnt == ARM_LAST) begin
                    arm_cnt_nxt = 16'd0;
                    state_nxt   = S_SETUP;
                end else begin
                    arm_cnt_nxt = arm_cnt + 16'd1;
                end
            end
            S_SETUP: begin
                idx_nxt   = 3'd0;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (idx == 3'd7) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt = idx + 3'd1;
                end
            end
            default: state_nxt = S_DONE;
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it
        csib_nxt  = 1'b1;
        rdwrb_nxt = 1'b1;
        data_nxt  = 32'hFFFF_FFFF;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state_nxt)
            S_SETUP: begin
                rdwrb_nxt = 1'b0;
                busy_nxt  = 1'b1;
            end
            S_WRITE: begin
                csib_nxt  = 1'b0;
                rdwrb_nxt = 1'b0;
                busy_nxt  = 1'b1;
                data_nxt  = BITSWAP ? byte_swap_bits(iprog_word(idx_nxt)) : iprog_word(idx_nxt);
            end
            S_DONE: begin
                done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            arm_cnt    <= 16'd0;
            idx        <= 3'd0;
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b1;
            icap_i     <= 32'hFFFF_FFFF;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            arm_cnt    <= arm_cnt_nxt;
            idx        <= idx_nxt;
            icap_csib  <= csib_nxt;
            icap_rdwrb <= rdwrb_nxt;
            icap_i     <= data_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_icape2_multiboot_seq.sv
// tb/tb_icape2_multiboot_seq.sv - directed scoreboard bench for icape2_multiboot_seq
module tb_icape2_multiboot_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        boot_a = 1'b0;
    logic        boot_b = 1'b0;
    logic        csib_a, rdwrb_a, busy_a, done_a;
    logic        csib_b, rdwrb_b, busy_b, done_b;
    logic [31:0] i_a, i_b;

    int nvec = 0;
    int nerr = 0;
    int low_a = 0;
    int low_b = 0;
    logic prev_csib_a = 1'b1, prev_rdwrb_a = 1'b1;
    logic prev_csib_b = 1'b1, prev_rdwrb_b = 1'b1;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    localparam logic [31:0] SWAPPED [8] = '{32'hFFFFFFFF, 32'h5599AA66, 32'h04000000, 32'h0C400080,
                                            32'h00020000, 32'h0C000180, 32'h000000F0, 32'h04000000};
    localparam logic [31:0] PLAIN [8]   = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h30020001,
                                            32'h00400000, 32'h30008001, 32'h0000000F, 32'h20000000};

    icape2_multiboot_seq #(.START_ADDRESS(32'h00400000), .ARM_CYCLES(16), .BITSWAP(1'b1)) dut_a (
        .clk(clk), .reset(reset), .boot(boot_a), .icap_csib(csib_a), .icap_rdwrb(rdwrb_a),
        .icap_i(i_a), .busy(busy_a), .done(done_a));

    icape2_multiboot_seq #(.START_ADDRESS(32'h00400000), .ARM_CYCLES(1), .BITSWAP(1'b0)) dut_b (
        .clk(clk), .reset(reset), .boot(boot_b), .icap_csib(csib_b), .icap_rdwrb(rdwrb_b),
        .icap_i(i_b), .busy(busy_b), .done(done_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_csib"}, {31'd0, csib_a}, 32'd1);
        chk({tag, "_rdwrb"}, {31'd0, rdwrb_a}, 32'd1);
        chk({tag, "_i"}, i_a, 32'hFFFFFFFF);
        chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
    endtask

    task automatic push_a();
        for (int n = 0; n < 8; n++) q_a.push_back(SWAPPED[n]);
    endtask

    // One clock; outputs are sampled 1 time unit after the edge and scored against the queues
    task automatic cyc();
        @(posedge clk);
        #1;
        if (!csib_a) begin
            low_a++;
            chk("a_rdwrb_low_with_csib", {31'd0, rdwrb_a}, 32'd0);
            if (prev_csib_a) chk("a_rdwrb_before_csib", {31'd0, prev_rdwrb_a}, 32'd0);
            if (q_a.size() == 0) chk("a_unexpected_word", 32'd1, 32'd0);
            else chk("a_word", i_a, q_a.pop_front());
        end
        if (!csib_b) begin
            low_b++;
            chk("b_rdwrb_low_with_csib", {31'd0, rdwrb_b}, 32'd0);
            if (prev_csib_b) chk("b_rdwrb_before_csib", {31'd0, prev_rdwrb_b}, 32'd0);
            if (q_b.size() == 0) chk("b_unexpected_word", 32'd1, 32'd0);
            else chk("b_word", i_b, q_b.pop_front());
        end
        prev_csib_a  = csib_a;
        prev_rdwrb_a = rdwrb_a;
        prev_csib_b  = csib_b;
        prev_rdwrb_b = rdwrb_b;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        boot_a = 1'b0;
        boot_b = 1'b0;
        cyc();
        reset = 1'b0;
        q_a.delete();
        q_b.delete();
        low_a = 0;
        low_b = 0;
    endtask

    task automatic wait_csib_low_a(input string tag);
        int found;
        found = 0;
        for (int n = 0; n < 40 && found == 0; n++) begin
            cyc();
            if (!csib_a) found = 1;
        end
        chk(tag, found, 1);
    endtask

    initial begin
        // Reset state, then a long idle stretch
        @(posedge clk);
        #1;
        do_reset();
        chk_idle_a("reset");
        for (int n = 0; n < 100; n++) cyc();
        chk_idle_a("idle100");
        chk("idle_csib_low_cycles", low_a, 0);

        // Held boot: 16 qualifying samples, one SETUP cycle, 8 words, then done
        boot_a = 1'b1;
        push_a();
        for (int n = 0; n < 15; n++) cyc();
        chk("arm_not_yet_busy", {31'd0, busy_a}, 32'd0);
        cyc();
        chk("setup_busy", {31'd0, busy_a}, 32'd1);
        chk("setup_rdwrb", {31'd0, rdwrb_a}, 32'd0);
        chk("setup_csib", {31'd0, csib_a}, 32'd1);
        for (int n = 0; n < 8; n++) cyc();
        chk("word7_done_low", {31'd0, done_a}, 32'd0);
        cyc();
        chk("seq_done", {31'd0, done_a}, 32'd1);
        chk("seq_busy_fell", {31'd0, busy_a}, 32'd0);
        chk("seq_csib_high", {31'd0, csib_a}, 32'd1);
        chk("seq_i_idle", i_a, 32'hFFFFFFFF);
        chk("seq_low_cycles", low_a, 8);
        chk("seq_queue_empty", q_a.size(), 0);

        // Glitch rejection: 15 high, 1 low, then 16 more before SETUP
        do_reset();
        boot_a = 1'b1;
        for (int n = 0; n < 15; n++) cyc();
        boot_a = 1'b0;
        cyc();
        boot_a = 1'b1;
        push_a();
        for (int n = 0; n < 15; n++) cyc();
        chk("glitch_not_busy", {31'd0, busy_a}, 32'd0);
        chk("glitch_no_csib", low_a, 0);
        cyc();
        chk("glitch_setup_busy", {31'd0, busy_a}, 32'd1);
        for (int n = 0; n < 9; n++) cyc();
        chk("glitch_done", {31'd0, done_a}, 32'd1);
        chk("glitch_low_cycles", low_a, 8);

        // Boot dropped just after CSIB falls; then held high in DONE
        do_reset();
        boot_a = 1'b1;
        push_a();
        wait_csib_low_a("drop_csib_fell");
        boot_a = 1'b0;
        for (int n = 0; n < 8; n++) cyc();
        chk("drop_done", {31'd0, done_a}, 32'd1);
        chk("drop_low_cycles", low_a, 8);
        chk("drop_queue_empty", q_a.size(), 0);
        boot_a = 1'b1;
        for (int n = 0; n < 200; n++) cyc();
        chk("done_hold_low_cycles", low_a, 8);
        chk("done_hold_done", {31'd0, done_a}, 32'd1);

        // Reset while word 4 is on the bus, then a complete rerun
        do_reset();
        boot_a = 1'b1;
        push_a();
        wait_csib_low_a("rst_mid_csib_fell");
        for (int n = 0; n < 4; n++) cyc();
        chk("rst_mid_word4", i_a, 32'h00020000);
        do_reset();
        chk_idle_a("rst_mid");
        boot_a = 1'b1;
        push_a();
        for (int n = 0; n < 25; n++) cyc();
        chk("rerun_done", {31'd0, done_a}, 32'd1);
        chk("rerun_low_cycles", low_a, 8);
        chk("rerun_queue_empty", q_a.size(), 0);

        // Unswapped, single-cycle arm on the second instance
        do_reset();
        for (int n = 0; n < 8; n++) q_b.push_back(PLAIN[n]);
        boot_b = 1'b1;
        cyc();
        chk("b_setup_busy", {31'd0, busy_b}, 32'd1);
        chk("b_setup_rdwrb", {31'd0, rdwrb_b}, 32'd0);
        chk("b_setup_csib", {31'd0, csib_b}, 32'd1);
        for (int n = 0; n < 8; n++) cyc();
        chk("b_word7_done_low", {31'd0, done_b}, 32'd0);
        cyc();
        chk("b_done", {31'd0, done_b}, 32'd1);
        chk("b_low_cycles", low_b, 8);
        chk("b_queue_empty", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
